// File: rtl/delay_chain_sensor.sv
// rtl/delay_chain_sensor.sv - inverter delay-chain probe with sampled thermometer decode and averaging

// One inverting delay stage; with ctl=0 and enable=1 it is a plain NOT.
module singlepath_1 (
  input  logic in_i,
  input  logic enable,
  input  logic ctl,
  output logic out_o
);
  assign out_o = enable & (in_i ^ ~ctl);
endmodule

module delay_chain_sensor #(
  parameter int CHAIN_LEN     = 16,
  parameter int SAMPLES_LOG2  = 2,
  parameter int SETTLE_CYCLES = 4,
  localparam int CW           = $clog2(CHAIN_LEN + 1),
  localparam int SW           = CW + SAMPLES_LOG2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] lastCount,
  output logic [SW-1:0] sumCount,
  output logic [CW-1:0] avgCount,
  output logic          bubbleErr
);
  localparam int M   = 1 << SAMPLES_LOG2;
  localparam int IW  = SAMPLES_LOG2 + 1;
  localparam int STW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IW-1:0]  LAST_IDX   = IW'(M - 1);
  localparam logic [STW-1:0] SETTLE_END = STW'(SETTLE_CYCLES - 1);

  localparam logic [2:0] ST_SETTLE  = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_DECODE  = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [STW-1:0]       settle_cnt_q, settle_cnt_d;
  logic                 launch_q, launch_d;
  logic                 meas_q, meas_d;
  logic [CHAIN_LEN-1:0] tap_q, tap_d;
  logic [IW-1:0]        sample_idx_q, sample_idx_d;
  logic [SW-1:0]        sum_q, sum_d;
  logic [CW-1:0]        last_count_q, last_count_d;
  logic [SW-1:0]        sum_count_q, sum_count_d;
  logic [CW-1:0]        avg_count_q, avg_count_d;
  logic                 bubble_q, bubble_d;

  // Raw chain outputs; kept so synthesis preserves every stage.
  (* keep *) logic [CHAIN_LEN-1:0] taps;

  logic [CHAIN_LEN-1:0] norm;
  logic [CW-1:0]        dec_count;
  logic                 dec_bubble;
  logic                 seen_zero;
  logic [SW-1:0]        sum_total;

  for (genvar g = 0; g < CHAIN_LEN; g++) begin : g_stage
    if (g == 0) begin : g_first
      singlepath_1 u_stage (.in_i(launch_q), .enable(1'b1), .ctl(1'b0), .out_o(taps[g]));
    end else begin : g_rest
      singlepath_1 u_stage (.in_i(taps[g-1]), .enable(1'b1), .ctl(1'b0), .out_o(taps[g]));
    end
  end

  // Normalise taps against their settled value so the decode ignores launch polarity,
  // then count leading ones and flag any one sitting above the first zero.
  always_comb begin
    dec_count  = '0;
    dec_bubble = 1'b0;
    seen_zero  = 1'b0;
    norm       = '0;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      norm[i] = (tap_q[i] == ((i % 2 == 0) ? ~launch_q : launch_q));
      if (norm[i]) begin
        if (seen_zero) dec_bubble = 1'b1;
        else           dec_count  = dec_count + CW'(1);
      end else begin
        seen_zero = 1'b1;
      end
    end
    sum_total = sum_q + SW'(dec_count);
  end

  // Measurement sequencer: launch, capture one clock later, decode, settle, repeat.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    launch_d     = launch_q;
    meas_d       = meas_q;
    tap_d        = tap_q;
    sample_idx_d = sample_idx_q;
    sum_d        = sum_q;
    last_count_d = last_count_q;
    sum_count_d  = sum_count_q;
    avg_count_d  = avg_count_q;
    bubble_d     = bubble_q;
    case (state_q)
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_END) begin
          settle_cnt_d = '0;
          if (meas_q) begin
            launch_d = ~launch_q;
            state_d  = ST_CAPTURE;
          end else begin
            state_d  = ST_IDLE;
          end
        end else begin
          settle_cnt_d = settle_cnt_q + STW'(1);
        end
      end
      ST_IDLE: begin
        if (start) begin
          launch_d     = ~launch_q;
          sum_d        = '0;
          bubble_d     = 1'b0;
          sample_idx_d = '0;
          meas_d       = 1'b1;
          state_d      = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        tap_d   = taps;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        last_count_d = dec_count;
        sum_d        = sum_total;
        bubble_d     = bubble_q | dec_bubble;
        sample_idx_d = sample_idx_q + IW'(1);
        if (sample_idx_q == LAST_IDX) begin
          // Publish results on entry to FINISH so they are valid alongside done.
          sum_count_d = sum_total;
          avg_count_d = sum_total[SW-1:SAMPLES_LOG2];
          meas_d      = 1'b0;
          state_d     = ST_FINISH;
        end else begin
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_SETTLE;
    endcase
  end

  // State and datapath registers; reset aborts any run and re-enters the settle period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SETTLE;
      settle_cnt_q <= '0;
      launch_q     <= 1'b0;
      meas_q       <= 1'b0;
      tap_q        <= '0;
      sample_idx_q <= '0;
      sum_q        <= '0;
      last_count_q <= '0;
      sum_count_q  <= '0;
      avg_count_q  <= '0;
      bubble_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      launch_q     <= launch_d;
      meas_q       <= meas_d;
      tap_q        <= tap_d;
      sample_idx_q <= sample_idx_d;
      sum_q        <= sum_d;
      last_count_q <= last_count_d;
      sum_count_q  <= sum_count_d;
      avg_count_q  <= avg_count_d;
      bubble_q     <= bubble_d;
    end
  end

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done      = (state_q == ST_FINISH);
  assign lastCount = last_count_q;
  assign sumCount  = sum_count_q;
  assign avgCount  = avg_count_q;
  assign bubbleErr = bubble_q;
endmodule

// File: tb/tb_delay_chain_sensor.sv
// tb/tb_delay_chain_sensor.sv - directed self-checking bench for delay_chain_sensor
module tb_delay_chain_sensor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;

  logic       busy, done, bubble_err;
  logic [4:0] last_count, avg_count;
  logic [6:0] sum_count;

  logic       busy2, done2, bubble_err2;
  logic [2:0] last_count2, avg_count2, sum_count2;

  int checks = 0;
  int errors = 0;
  int force_mode = 0;
  logic [15:0] tap_force;
  int de, nd;

  delay_chain_sensor dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .lastCount(last_count), .sumCount(sum_count), .avgCount(avg_count), .bubbleErr(bubble_err)
  );

  delay_chain_sensor #(.CHAIN_LEN(7), .SAMPLES_LOG2(0), .SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .lastCount(last_count2), .sumCount(sum_count2), .avgCount(avg_count2), .bubbleErr(bubble_err2)
  );

  always #5 clk = ~clk;

  // Drive the chain outputs so the normalised pattern equals the requested one.
  always @(negedge clk) begin
    if (force_mode != 0) begin
      logic [15:0] n;
      logic s;
      if (force_mode == 1) n = 16'h001F;
      else n = (dut.sample_idx_q == 3'd2) ? 16'h000B : 16'hFFFF;
      for (int i = 0; i < 16; i++) begin
        s = (i % 2 == 0) ? ~dut.launch_q : dut.launch_q;
        tap_force[i] = n[i] ? s : ~s;
      end
      force dut.taps = tap_force;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Start a run, optionally pulse start again at edges p1/p2, optionally reset after edge abort_at.
  task automatic run_meas(input int which, input int p1, input int p2, input int abort_at,
                          output int done_edge, output int ndone);
    logic drv;
    done_edge = -1;
    ndone = 0;
    for (int e = 1; e <= 30; e++) begin
      drv = (e == 1) || (e == p1) || (e == p2);
      if (which == 0) start = drv; else start2 = drv;
      tick;
      if ((which == 0) ? done : done2) begin
        ndone++;
        if (done_edge < 0) done_edge = e;
      end
      if (e == abort_at) begin
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 1);
        check("abort_done", done, 0);
        check("abort_last", last_count, 0);
        check("abort_sum", sum_count, 0);
        check("abort_avg", avg_count, 0);
        check("abort_bubble", bubble_err, 0);
        break;
      end
    end
    start = 1'b0;
    start2 = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_last", last_count, 0);
    check("rst_sum", sum_count, 0);
    check("rst_avg", avg_count, 0);
    check("rst_bubble", bubble_err, 0);
    repeat (2) tick;
    rst = 1'b0;
    repeat (3) tick;
    check("settle_busy_3", busy, 1);
    tick;
    check("settle_busy_4", busy, 0);

    run_meas(0, 0, 0, 0, de, nd);
    check("t2_done_edge", de, 21);
    check("t2_ndone", nd, 1);
    check("t2_last", last_count, 16);
    check("t2_sum", sum_count, 64);
    check("t2_avg", avg_count, 16);
    check("t2_bubble", bubble_err, 0);
    check("t2_launch", dut.launch_q, 0);

    force_mode = 1;
    run_meas(0, 0, 0, 0, de, nd);
    check("t3_last", last_count, 5);
    check("t3_sum", sum_count, 20);
    check("t3_avg", avg_count, 5);
    check("t3_bubble", bubble_err, 0);

    force_mode = 2;
    run_meas(0, 0, 0, 0, de, nd);
    check("t4_last", last_count, 16);
    check("t4_sum", sum_count, 50);
    check("t4_avg", avg_count, 12);
    check("t4_bubble", bubble_err, 1);
    force_mode = 0;
    release dut.taps;
    run_meas(0, 0, 0, 0, de, nd);
    check("t4_clear_bubble", bubble_err, 0);
    check("t4_clear_sum", sum_count, 64);

    run_meas(0, 3, 10, 0, de, nd);
    check("t5_done_edge", de, 21);
    check("t5_ndone", nd, 1);

    run_meas(0, 0, 0, 12, de, nd);
    tick;
    rst = 1'b0;
    nd = 0;
    for (int e = 0; e < 30; e++) begin
      tick;
      if (done) nd++;
    end
    check("t5_abort_ndone", nd, 0);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_sum", sum_count, 0);
    check("t5_abort_last", last_count, 0);

    run_meas(1, 0, 0, 0, de, nd);
    check("t6_done_edge", de, 3);
    check("t6_ndone", nd, 1);
    check("t6_last", last_count2, 7);
    check("t6_sum", sum_count2, 7);
    check("t6_avg", avg_count2, 7);
    check("t6_bubble", bubble_err2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
